// File: rtl/seg7_pkg.sv
// Purpose: shared seven-segment constants (segment indices, hex glyph table, FSM state type).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Used by both the display encoder and the scan decoder, so the two ends share one glyph table.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Segment bit positions on the bus: bit0=a ... bit6=g
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Hex glyphs, gfedcba, active-high
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Purpose: decode one active-high segment pattern back to a hex nibble.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern[6:0] (gfedcba) in; hit=1 when the pattern is a legal glyph; nibble out (0 on miss).
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             hit,
    output logic [3:0]       nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: begin
                hit    = 1'b0;
                nibble = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Purpose: sample a multiplexed 7-seg bus, deglitch, decode per digit and emit whole frames.
// Latency: digit commits STABLE+1 edges after a pattern appears; frame_valid rises on the completing commit edge.
// Backpressure: frame held while frame_ready=0; a further completed frame is dropped and overflow sticks.
// Ports: clk, rst (sync, active-high); seg_in[6:0], dig_sel[NDIG-1:0] pins; frame_ready in;
//        frame_valid, frame_value[4*NDIG-1:0], frame_err[NDIG-1:0], overflow out.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEG_W-1:0]    seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                frame_ready,
    output logic                frame_valid,
    output logic [4*NDIG-1:0]   frame_value,
    output logic [NDIG-1:0]     frame_err,
    output logic                overflow
);

    localparam int SW = SEG_W + NDIG;
    localparam int CW = (STABLE > 2) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE - 2);

    // ---------------- entry and stability ----------------
    logic [SW-1:0]  pin_sample;
    logic [SW-1:0]  cur_sample;
    logic [SW-1:0]  prev_sample;
    logic [CW-1:0]  cnt;
    logic           same;
    logic           commit;
    logic           onehot;
    logic [NDIG-1:0] cur_dig;
    logic [SEG_W-1:0] cur_seg;

    assign pin_sample = (ACTIVE_LOW != 0) ? ~{dig_sel, seg_in} : {dig_sel, seg_in};
    assign cur_dig    = cur_sample[SW-1:SEG_W];
    assign cur_seg    = cur_sample[SEG_W-1:0];
    assign same       = (cur_sample == prev_sample);
    assign onehot     = (cur_dig != '0) && ((cur_dig & (cur_dig - NDIG'(1))) == '0);
    // Fires only on the transition into saturation, so a held pattern commits once.
    assign commit     = same && (cnt == CNT_PRE) && onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sample  <= '0;
            prev_sample <= '0;
            cnt         <= '0;
        end else begin
            cur_sample  <= pin_sample;
            prev_sample <= cur_sample;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
        end
    end

    // ---------------- decode and shadow ----------------
    logic             hit;
    logic [3:0]       nibble;

    seg7_to_hex u_dec (
        .pattern (cur_seg),
        .hit     (hit),
        .nibble  (nibble)
    );

    logic [4*NDIG-1:0] shadow_val;
    logic [4*NDIG-1:0] shadow_val_nxt;
    logic [NDIG-1:0]   shadow_err;
    logic [NDIG-1:0]   shadow_err_nxt;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   seen_nxt;
    logic              complete;

    always_comb begin
        shadow_val_nxt = shadow_val;
        shadow_err_nxt = shadow_err;
        seen_nxt       = seen;
        if (commit) begin
            seen_nxt = seen | cur_dig;
            for (int i = 0; i < NDIG; i++) begin
                if (cur_dig[i]) begin
                    shadow_val_nxt[4*i +: 4] = nibble;
                    shadow_err_nxt[i]        = ~hit;
                end
            end
        end
    end

    // Completion looks at the post-commit view so the finishing digit is in the frame.
    assign complete = &seen_nxt;

    // ---------------- frame FSM ----------------
    scan_state_t state;
    scan_state_t state_nxt;
    logic        load_frame;
    logic        clear_seen;
    logic        set_ovf;
    logic        valid_nxt;
    logic        hs;

    assign hs = frame_valid & frame_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_frame = 1'b0;
        clear_seen = 1'b0;
        set_ovf    = 1'b0;
        valid_nxt  = frame_valid;
        case (state)
            ST_COLLECT: begin
                if (complete) begin
                    load_frame = 1'b1;
                    clear_seen = 1'b1;
                    valid_nxt  = 1'b1;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (complete && hs) begin
                    // Back-to-back: consumer takes the old frame as the new one lands.
                    load_frame = 1'b1;
                    clear_seen = 1'b1;
                    valid_nxt  = 1'b1;
                end else if (complete) begin
                    clear_seen = 1'b1;
                    set_ovf    = 1'b1;
                end else if (hs) begin
                    valid_nxt  = 1'b0;
                    state_nxt  = ST_COLLECT;
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val  <= '0;
            shadow_err  <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            frame_value <= '0;
            frame_err   <= '0;
            overflow    <= 1'b0;
        end else begin
            shadow_val  <= shadow_val_nxt;
            shadow_err  <= shadow_err_nxt;
            seen        <= clear_seen ? '0 : seen_nxt;
            frame_valid <= valid_nxt;
            if (load_frame) begin
                frame_value <= shadow_val_nxt;
                frame_err   <= shadow_err_nxt;
            end
            if (set_ovf)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the seven-segment display path. Samples a multiplexed display bus (segment lines plus one-hot digit select), deglitches it, and decodes each segment pattern back to a hex nibble. It assembles one nibble per digit into a frame and hands the frame out over a valid/ready handshake. It sits on the simulation/loopback side of the NPC so that ALU and debug output driven to the display can be checked numerically.

## Interface
- `NDIG`, 8: number of multiplexed digits; value width is 4*NDIG.
- `STABLE`, 4: consecutive identical samples required before a digit is committed; must be ≥ 2.
- `ACTIVE_LOW`, 1: 1 means `seg_in` and `dig_sel` are active-low on the pins; both are inverted at entry.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seg_in` input 7: segment lines, bit0=a … bit6=g.
- `dig_sel` input NDIG: digit enable, one-hot after polarity correction.
- `frame_ready` input 1: consumer accepts the frame when high with `frame_valid`.
- `frame_valid` output 1: frame outputs hold a complete frame.
- `frame_value` output 4*NDIG: nibble i in bits [4i+3:4i].
- `frame_err` output NDIG: bit i set when digit i's pattern was not a legal hex glyph.
- `overflow` output 1: sticky; a completed frame was dropped.

## Operation
- Entry: optional inversion, then register {dig_sel, seg_in} as the current sample.
- Stability counter: reset to 0 when the current sample differs from the previous one. Otherwise it increments and saturates at STABLE-1. Commit fires once, on the edge where the counter reaches STABLE-1. No re-commit happens until the sample changes.
- Commit: `dig_sel` must be exactly one-hot. Zero or multiple bits set means no commit, with no other effect.
  - Committed pattern decodes via table (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Any other pattern (including blank 00): nibble 0, shadow error bit set.
  - Writes shadow nibble/err for the selected digit and sets seen[i]. Re-commit of a seen digit overwrites it.
- FSM:
  - COLLECT: when seen becomes all-ones, copy shadow to frame outputs, clear seen, and assert `frame_valid`. Next state is HOLD.
  - HOLD: collection continues into the shadow. A handshake (`frame_valid & frame_ready`) deasserts `frame_valid` and returns to COLLECT.
  - If seen completes in HOLD without a handshake that cycle, the frame is dropped, seen is cleared, and `overflow` sets.
  - If seen completes in the same cycle as the handshake, the new frame loads, `frame_valid` stays 1, and the state stays HOLD.
- `overflow` clears only on `rst`.
- Frame outputs are stable whenever `frame_valid`=1 and no handshake occurs.

## Timing
- Reset: `frame_valid`=0, `frame_value`=0, `frame_err`=0, `overflow`=0. The shadow, seen, counter, sample registers and FSM (COLLECT) are all cleared.
- Reset asserted mid-frame discards the partial frame; the first sample after release compares against the zeroed register.
- Latency: a new pattern held constant is committed STABLE+1 edges after it first appears on the pins (1 entry register + STABLE compares).
- Completing digit commit → `frame_valid` high on the same edge as that commit.
- `frame_valid` falls on the edge after the handshake cycle, unless reloaded.
- Glitches shorter than STABLE samples never commit.

## Structure
- Package `seg7_pkg`: segment-index constants, the 16 glyph constants, and `SEG_W`=7. These are shared with the display encoder so both ends use one table.
- Sub-module `seg7_to_hex`: combinational, pattern[6:0] → {hit, nibble[3:0]}.
- Top: entry/stability logic, shadow registers, FSM.

## Test plan
- NDIG=2, STABLE=4, active-low: hold dig_sel=~2'b01 with seg=~7'h06 for 6 cycles, then dig_sel=~2'b10 with seg=~7'h4F for 6 cycles → `frame_valid`=1, `frame_value`=8'h31, `frame_err`=0.
- Same, but digit1 pattern 7'h27 → `frame_value`[7:4]=0, `frame_err`=2'b10.
- Digit0 pattern held only 3 cycles, then changed → no commit; seen[0] stays 0 and no frame is produced.
- `frame_ready`=0 with two full frames collected → first frame held unchanged and `overflow`=1. Then assert ready with a third frame completing the same cycle → `frame_valid` stays 1 and the outputs show the third frame.
- dig_sel=~2'b11 or ~2'b00 held 10 cycles → no commit, no frame.
- Assert `rst` after digit0 committed → all outputs 0. After release, digit1 alone does not produce a frame; both digits are required.
